// File: rtl/cr_prefix_fe_bcnt_pkg.sv
// cr_prefix_fe_bcnt_pkg: shared types, FIFO sizing defaults and saturating add for the byte counter front-end
package cr_prefix_fe_bcnt_pkg;
  localparam int FE_CTR_DEPTH = 4;
  localparam int FE_CTR_AFULL = 3;
  typedef struct packed {
    logic [63:0] tdata;
  } tlvp_if_bus_t;
  typedef struct packed {
    logic [11:0] byte_cnt;
    logic [11:0] zero_cnt;
  } fe_ctr_rec_t;
  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [3:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction
endpackage

// File: rtl/cr_prefix_fe_fifo.sv
// cr_prefix_fe_fifo: single-clock record FIFO with full/afull/empty flags and sticky drop flag
module cr_prefix_fe_fifo
  import cr_prefix_fe_bcnt_pkg::*;
#(
  parameter int DEPTH = FE_CTR_DEPTH,
  parameter int AFULL = FE_CTR_AFULL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  fe_ctr_rec_t din,
  output fe_ctr_rec_t dout,
  output logic        empty,
  output logic        full,
  output logic        afull,
  output logic        ovfl
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fe_ctr_rec_t   mem_q [DEPTH];
  fe_ctr_rec_t   mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovfl_q, ovfl_d;
  logic          push, pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign afull = cnt_q >= CW'(AFULL);
  assign ovfl  = ovfl_q;
  assign dout  = mem_q[rp_q];
  always_comb begin
    pop   = rd && !empty;
    push  = wr && (!full || pop);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d   = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d   = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovfl_d = ovfl_q || (wr && !push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovfl_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovfl_q <= ovfl_d;
    end
  end
endmodule

// File: rtl/cr_prefix_fe_bcnt.sv
// cr_prefix_fe_bcnt: per-block byte/zero-byte counter with a hold register fanned out into four record FIFOs
module cr_prefix_fe_bcnt
  import cr_prefix_fe_bcnt_pkg::fe_ctr_rec_t;
  import cr_prefix_fe_bcnt_pkg::tlvp_if_bus_t;
  import cr_prefix_fe_bcnt_pkg::sat_add12;
#(
  parameter int FE_CTR_DEPTH = cr_prefix_fe_bcnt_pkg::FE_CTR_DEPTH,
  parameter int FE_CTR_AFULL = cr_prefix_fe_bcnt_pkg::FE_CTR_AFULL
) (
  input  logic         clk,
  input  logic         rst,
  input  tlvp_if_bus_t ibc_data_tlv,
  input  logic [7:0]   ibc_data_vbytes,
  input  logic [1:0]   ibc_blk_sel,
  input  logic         ibc_ctr_reload,
  input  logic         ibc_ctr_1_wr,
  input  logic         ibc_ctr_2_wr,
  input  logic         ibc_ctr_3_wr,
  input  logic         ibc_ctr_4_wr,
  output logic         fe_ctr_1_ib_full,
  output logic         fe_ctr_2_ib_full,
  output logic         fe_ctr_3_ib_full,
  output logic         fe_ctr_4_ib_full,
  output logic         fe_ctr_1_ib_afull,
  output logic         fe_ctr_2_ib_afull,
  output logic         fe_ctr_3_ib_afull,
  output logic         fe_ctr_4_ib_afull,
  input  logic         fe_ctr_1_rd,
  input  logic         fe_ctr_2_rd,
  input  logic         fe_ctr_3_rd,
  input  logic         fe_ctr_4_rd,
  output logic         fe_ctr_1_empty,
  output logic         fe_ctr_2_empty,
  output logic         fe_ctr_3_empty,
  output logic         fe_ctr_4_empty,
  output fe_ctr_rec_t  fe_ctr_1_data,
  output fe_ctr_rec_t  fe_ctr_2_data,
  output fe_ctr_rec_t  fe_ctr_3_data,
  output fe_ctr_rec_t  fe_ctr_4_data,
  output logic         fe_ctr_1_ovfl,
  output logic         fe_ctr_2_ovfl,
  output logic         fe_ctr_3_ovfl,
  output logic         fe_ctr_4_ovfl
);
  logic [11:0] accb_q, accb_d, accz_q, accz_d, sb, sz;
  fe_ctr_rec_t hold_q, hold_d;
  logic [3:0]  nb, nz, wr_v, rd_v, empty_v, full_v, afull_v, ovfl_v;
  fe_ctr_rec_t dout_v [4];
  logic        unused_blk_sel;
  assign unused_blk_sel = ^ibc_blk_sel;
  always_comb begin
    nb = '0;
    nz = '0;
    for (int i = 0; i < 8; i++) begin
      nb = nb + 4'(ibc_data_vbytes[i]);
      nz = nz + 4'(ibc_data_vbytes[i] && ibc_data_tlv.tdata[8*i +: 8] == 8'h00);
    end
    sb     = sat_add12(accb_q, nb);
    sz     = sat_add12(accz_q, nz);
    accb_d = ibc_ctr_reload ? '0 : sb;
    accz_d = ibc_ctr_reload ? '0 : sz;
    hold_d = ibc_ctr_reload ? {sb, sz} : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      accb_q <= '0;
      accz_q <= '0;
      hold_q <= '0;
    end else begin
      accb_q <= accb_d;
      accz_q <= accz_d;
      hold_q <= hold_d;
    end
  end
  assign wr_v = {ibc_ctr_4_wr, ibc_ctr_3_wr, ibc_ctr_2_wr, ibc_ctr_1_wr};
  assign rd_v = {fe_ctr_4_rd, fe_ctr_3_rd, fe_ctr_2_rd, fe_ctr_1_rd};
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    cr_prefix_fe_fifo #(
      .DEPTH(FE_CTR_DEPTH),
      .AFULL(FE_CTR_AFULL)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr_v[g]),
      .rd   (rd_v[g]),
      .din  (hold_q),
      .dout (dout_v[g]),
      .empty(empty_v[g]),
      .full (full_v[g]),
      .afull(afull_v[g]),
      .ovfl (ovfl_v[g])
    );
  end
  assign {fe_ctr_4_ib_full, fe_ctr_3_ib_full, fe_ctr_2_ib_full, fe_ctr_1_ib_full} = full_v;
  assign {fe_ctr_4_ib_afull, fe_ctr_3_ib_afull, fe_ctr_2_ib_afull, fe_ctr_1_ib_afull} = afull_v;
  assign {fe_ctr_4_empty, fe_ctr_3_empty, fe_ctr_2_empty, fe_ctr_1_empty} = empty_v;
  assign {fe_ctr_4_ovfl, fe_ctr_3_ovfl, fe_ctr_2_ovfl, fe_ctr_1_ovfl} = ovfl_v;
  assign fe_ctr_1_data = dout_v[0];
  assign fe_ctr_2_data = dout_v[1];
  assign fe_ctr_3_data = dout_v[2];
  assign fe_ctr_4_data = dout_v[3];
endmodule

// File: tb/tb_cr_prefix_fe_bcnt.sv
// tb_cr_prefix_fe_bcnt: directed scoreboard bench for the byte counter front-end
module tb_cr_prefix_fe_bcnt;
  import cr_prefix_fe_bcnt_pkg::*;
  logic         clk = 1'b0;
  logic         rst;
  tlvp_if_bus_t bus;
  logic [7:0]   vb;
  logic [1:0]   bsel;
  logic         reload;
  logic [3:0]   wr, rd, full, afull, empty, ovfl;
  fe_ctr_rec_t  dout [4];
  int           checks = 0, errors = 0;
  logic [23:0]  q [4][$];
  bit           ov_m [4];
  int           acc_b, acc_z;
  logic [23:0]  hold_m;
  always #5 clk = ~clk;
  cr_prefix_fe_bcnt dut (
    .clk(clk), .rst(rst), .ibc_data_tlv(bus), .ibc_data_vbytes(vb), .ibc_blk_sel(bsel),
    .ibc_ctr_reload(reload),
    .ibc_ctr_1_wr(wr[0]), .ibc_ctr_2_wr(wr[1]), .ibc_ctr_3_wr(wr[2]), .ibc_ctr_4_wr(wr[3]),
    .fe_ctr_1_ib_full(full[0]), .fe_ctr_2_ib_full(full[1]),
    .fe_ctr_3_ib_full(full[2]), .fe_ctr_4_ib_full(full[3]),
    .fe_ctr_1_ib_afull(afull[0]), .fe_ctr_2_ib_afull(afull[1]),
    .fe_ctr_3_ib_afull(afull[2]), .fe_ctr_4_ib_afull(afull[3]),
    .fe_ctr_1_rd(rd[0]), .fe_ctr_2_rd(rd[1]), .fe_ctr_3_rd(rd[2]), .fe_ctr_4_rd(rd[3]),
    .fe_ctr_1_empty(empty[0]), .fe_ctr_2_empty(empty[1]),
    .fe_ctr_3_empty(empty[2]), .fe_ctr_4_empty(empty[3]),
    .fe_ctr_1_data(dout[0]), .fe_ctr_2_data(dout[1]), .fe_ctr_3_data(dout[2]), .fe_ctr_4_data(dout[3]),
    .fe_ctr_1_ovfl(ovfl[0]), .fe_ctr_2_ovfl(ovfl[1]), .fe_ctr_3_ovfl(ovfl[2]), .fe_ctr_4_ovfl(ovfl[3])
  );
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_flags(input string tag);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s_empty%0d", tag, n + 1), 24'(empty[n]), 24'(q[n].size() == 0));
      chk($sformatf("%s_full%0d", tag, n + 1), 24'(full[n]), 24'(q[n].size() == 4));
      chk($sformatf("%s_afull%0d", tag, n + 1), 24'(afull[n]), 24'(q[n].size() >= 3));
      chk($sformatf("%s_ovfl%0d", tag, n + 1), 24'(ovfl[n]), 24'(ov_m[n]));
    end
  endtask
  task automatic tick();
    int nb = 0;
    int nz = 0;
    for (int i = 0; i < 8; i++)
      if (vb[i]) begin
        nb++;
        if (bus.tdata[8*i +: 8] == 8'h00) nz++;
      end
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        ov_m[n] = 1'b0;
      end
      acc_b  = 0;
      acc_z  = 0;
      hold_m = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (rd[n] && q[n].size() > 0) begin
          chk($sformatf("head%0d", n + 1), dout[n], q[n][0]);
          void'(q[n].pop_front());
        end
        if (wr[n]) begin
          if (q[n].size() < 4) q[n].push_back(hold_m);
          else ov_m[n] = 1'b1;
        end
      end
      acc_b = (acc_b + nb > 4095) ? 4095 : acc_b + nb;
      acc_z = (acc_z + nz > 4095) ? 4095 : acc_z + nz;
      if (reload) begin
        hold_m = {12'(acc_b), 12'(acc_z)};
        acc_b  = 0;
        acc_z  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input logic [7:0] v, input logic [63:0] d, input logic rl,
                     input logic [3:0] w, input logic [3:0] r);
    vb        = v;
    bus.tdata = d;
    reload    = rl;
    wr        = w;
    rd        = r;
    tick();
  endtask
  initial begin
    rst = 1'b1; vb = '0; bus = '0; bsel = '0; reload = 1'b0; wr = '0; rd = '0;
    acc_b = 0; acc_z = 0; hold_m = '0;
    for (int n = 0; n < 4; n++) ov_m[n] = 1'b0;
    cyc(8'hFF, 64'h0, 1'b1, 4'hF, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'h0);
    rst = 1'b0;
    chk_flags("reset");
    for (int i = 0; i < 128; i++) begin
      bsel = 2'(i);
      cyc(8'hFF, (i % 4 == 0) ? 64'h0 : 64'h1111_1111_1111_1111, 1'b0, 4'h0, 4'h0);
    end
    cyc(8'h00, 64'h0, 1'b1, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'h0);
    chk_flags("blk");
    chk("blk_rec", dout[0], {12'd1024, 12'd256});
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0001);
    chk_flags("blk_pop");
    cyc(8'h0F, 64'h0000_0000_1100_2200, 1'b0, 4'h0, 4'h0);
    cyc(8'h01, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 4'h0, 4'h0);
    cyc(8'h03, 64'h1111_1111_1111_3300, 1'b1, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'h0);
    chk("part_rec", dout[0], {12'd7, 12'd4});
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0001);
    cyc(8'hAA, 64'h00FF_00FF_00FF_00FF, 1'b0, 4'h0, 4'h0);
    cyc(8'hF0, 64'h0000_0012_0000_0000, 1'b1, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'b1110, 4'h0);
    chk_flags("fan");
    chk("fan_rec2", dout[1], {12'd8, 12'd7});
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b1111);
    chk_flags("fan_pop");
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'h0);
      chk_flags($sformatf("ovf%0d", k + 1));
    end
    cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'b0001);
    chk_flags("ovf_pp");
    for (int k = 0; k < 4; k++) cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0001);
    chk_flags("drain");
    cyc(8'h00, 64'h0, 1'b0, 4'b0010, 4'b0010);
    chk_flags("pp_empty");
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0010);
    for (int i = 0; i < 520; i++) cyc(8'hFF, 64'h0, i == 519, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'h0);
    chk("sat_rec", dout[0], {12'hFFF, 12'hFFF});
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0001);
    cyc(8'h00, 64'h0, 1'b0, 4'b1100, 4'h0);
    for (int i = 0; i < 50; i++) cyc(8'hFF, 64'h1111_1111_1111_1111, 1'b0, 4'h0, 4'h0);
    rst = 1'b1;
    cyc(8'hFF, 64'h0, 1'b1, 4'hF, 4'h0);
    rst = 1'b0;
    chk_flags("midrst");
    for (int i = 0; i < 3; i++) cyc(8'hFF, 64'h1111_1111_1111_1111, 1'b0, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b1, 4'h0, 4'h0);
    cyc(8'h00, 64'h0, 1'b0, 4'b0001, 4'h0);
    chk("rst_rec", dout[0], {12'd24, 12'd0});
    cyc(8'h00, 64'h0, 1'b0, 4'h0, 4'b0001);
    chk_flags("end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
